// File: rtl/dilithium_stream_pkg.sv
// Shared constants for the Dilithium input framer: modes, section ids,
// per-level operand sizes in bits and the bits-to-words helper.
package dilithium_stream_pkg;

    localparam int BITS_W = 16;

    typedef logic [BITS_W-1:0] bits_t;

    localparam logic [1:0] MODE_KEYGEN  = 2'b00;
    localparam logic [1:0] MODE_SIGN    = 2'b10;
    localparam logic [1:0] MODE_VERIFY  = 2'b01;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [3:0] {
        SEC_RHO = 4'd0,
        SEC_KEY = 4'd1,
        SEC_TR  = 4'd2,
        SEC_S1  = 4'd3,
        SEC_S2  = 4'd4,
        SEC_T0  = 4'd5,
        SEC_T1  = 4'd6,
        SEC_C   = 4'd7,
        SEC_Z   = 4'd8,
        SEC_H   = 4'd9,
        SEC_MSG = 4'd10
    } sec_id_t;

    localparam bits_t SEED_BITS = 16'd256;

    // Indexed by sec_level (level 2 / 3 / 5); the fourth entry is the illegal level.
    localparam bits_t S1_BITS [4] = '{16'd3072,  16'd5120,  16'd5376,  16'd0};
    localparam bits_t S2_BITS [4] = '{16'd3072,  16'd6144,  16'd6144,  16'd0};
    localparam bits_t T1_BITS [4] = '{16'd10240, 16'd15360, 16'd20480, 16'd0};
    localparam bits_t T0_BITS [4] = '{16'd13312, 16'd19968, 16'd26624, 16'd0};
    localparam bits_t Z_BITS  [4] = '{16'd18432, 16'd25600, 16'd35840, 16'd0};
    localparam bits_t H_BITS  [4] = '{16'd672,   16'd488,   16'd664,   16'd0};

    function automatic bits_t words(input bits_t bits, input int w);
        int n;
        n = (int'(bits) + w - 1) / w;
        return bits_t'(n);
    endfunction

endpackage

// File: rtl/dilithium_section_rom.sv
// Section lookup: (mode, level, index) -> section id, size in bits and whether
// it is the final non-empty section of the operation.
module dilithium_section_rom
    import dilithium_stream_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [1:0] level,
    input  logic [2:0] index,
    input  bits_t      msg_bits,
    output sec_id_t    sec_id,
    output bits_t      bits,
    output logic       is_last_section
);

    logic msg_empty;

    assign msg_empty = (msg_bits == '0);

    // An empty MSG is skipped by ending the operation on the section before it.
    always_comb begin
        sec_id          = SEC_RHO;
        bits            = SEED_BITS;
        is_last_section = 1'b1;
        case (mode)
            MODE_SIGN: begin
                is_last_section = 1'b0;
                case (index)
                    3'd0: sec_id = SEC_RHO;
                    3'd1: sec_id = SEC_KEY;
                    3'd2: sec_id = SEC_TR;
                    3'd3: begin sec_id = SEC_S1; bits = S1_BITS[level]; end
                    3'd4: begin sec_id = SEC_S2; bits = S2_BITS[level]; end
                    3'd5: begin
                        sec_id          = SEC_T0;
                        bits            = T0_BITS[level];
                        is_last_section = msg_empty;
                    end
                    default: begin
                        sec_id          = SEC_MSG;
                        bits            = msg_bits;
                        is_last_section = 1'b1;
                    end
                endcase
            end
            MODE_VERIFY: begin
                is_last_section = 1'b0;
                case (index)
                    3'd0: sec_id = SEC_RHO;
                    3'd1: begin sec_id = SEC_T1; bits = T1_BITS[level]; end
                    3'd2: sec_id = SEC_C;
                    3'd3: begin sec_id = SEC_Z; bits = Z_BITS[level]; end
                    3'd4: begin
                        sec_id          = SEC_H;
                        bits            = H_BITS[level];
                        is_last_section = msg_empty;
                    end
                    default: begin
                        sec_id          = SEC_MSG;
                        bits            = msg_bits;
                        is_last_section = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dilithium_stream_framer.sv
// Frames an upstream word stream into the operand sections of a Dilithium
// KEYGEN / SIGN / VERIFY operation, tagging and tail-masking each word.
//
// state  | meaning
// IDLE   | waiting for start; config latched on a legal start
// STREAM | zero-latency pass-through, counting words per section
// DONE   | one-cycle done pulse, then back to IDLE
module dilithium_stream_framer
    import dilithium_stream_pkg::*;
#(
    parameter int W            = 64,
    parameter int MSG_MAX_BITS = 26400
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [1:0]                        mode,
    input  logic [1:0]                        sec_level,
    input  logic [$clog2(MSG_MAX_BITS+1)-1:0] msg_len,
    output logic                              busy,
    output logic                              done,
    output logic                              cfg_err,
    input  logic [W-1:0]                      din,
    input  logic                              din_valid,
    output logic                              din_ready,
    output logic [W-1:0]                      dout,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic [3:0]                        sec_id,
    output logic                              sec_first,
    output logic                              sec_last
);

    localparam int ML = $clog2(MSG_MAX_BITS + 1);
    localparam int LW = $clog2(W);

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, level_q;
    logic [ML-1:0]  msg_q;
    logic [2:0]     idx_q;
    bits_t          wcnt_q;
    sec_id_t        rom_id;
    bits_t          rom_bits;
    logic           rom_last;
    bits_t          sec_words;
    logic           final_word, in_stream, hs, cfg_ok, cfg_err_q;
    logic [LW-1:0]  tail_bits;
    logic [W-1:0]   mask;

    dilithium_section_rom u_rom (
        .mode            (mode_q),
        .level           (level_q),
        .index           (idx_q),
        .msg_bits        (BITS_W'(msg_q)),
        .sec_id          (rom_id),
        .bits            (rom_bits),
        .is_last_section (rom_last)
    );

    assign cfg_ok     = (mode != MODE_ILLEGAL) && (sec_level != 2'd3) &&
                        (msg_len <= ML'(MSG_MAX_BITS));
    assign in_stream  = (state_q == ST_STREAM);
    assign hs         = in_stream && din_valid && dout_ready && !abort;
    assign sec_words  = words(rom_bits, W);
    assign final_word = (wcnt_q == sec_words - bits_t'(1));
    assign tail_bits  = rom_bits[LW-1:0];
    assign cfg_err    = cfg_err_q;

    always_comb begin
        mask = '1;
        if (final_word && tail_bits != '0) begin
            for (int i = 0; i < W; i++) begin
                mask[i] = (i < int'(tail_bits));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && cfg_ok) state_d = ST_STREAM;
            ST_STREAM: begin
                if (abort)                             state_d = ST_IDLE;
                else if (hs && final_word && rom_last) state_d = ST_DONE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout       = '0;
        sec_id     = 4'd0;
        sec_first  = 1'b0;
        sec_last   = 1'b0;
        case (state_q)
            ST_STREAM: begin
                busy       = 1'b1;
                din_ready  = dout_ready;
                dout_valid = din_valid;
                dout       = din & mask;
                sec_id     = rom_id;
                sec_first  = (wcnt_q == '0);
                sec_last   = final_word;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_KEYGEN;
            level_q   <= '0;
            msg_q     <= '0;
            idx_q     <= '0;
            wcnt_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == ST_IDLE) && start && !cfg_ok;
            if (state_q == ST_IDLE && start && cfg_ok) begin
                mode_q  <= mode;
                level_q <= sec_level;
                msg_q   <= msg_len;
            end
            // Abort wins over a same-cycle handshake, so that word is never counted.
            if (!in_stream || abort) begin
                idx_q  <= '0;
                wcnt_q <= '0;
            end else if (hs) begin
                if (final_word) begin
                    wcnt_q <= '0;
                    idx_q  <= rom_last ? 3'd0 : idx_q + 3'd1;
                end else begin
                    wcnt_q <= wcnt_q + bits_t'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dilithium_stream_framer.sv
// Scoreboard bench for dilithium_stream_framer: expected words are built from an
// independent section model when stimulus is generated and popped on each handshake.
module tb_dilithium_stream_framer;

    localparam int W            = 64;
    localparam int MSG_MAX_BITS = 26400;
    localparam int ML           = $clog2(MSG_MAX_BITS + 1);
    localparam int CYC_LIMIT    = 6000;

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   sid;
        logic         first;
        logic         last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [1:0]    mode, sec_level;
    logic [ML-1:0] msg_len;
    logic          busy, done, cfg_err;
    logic [W-1:0]  din, dout;
    logic          din_valid, din_ready, dout_valid, dout_ready;
    logic [3:0]    sec_id;
    logic          sec_first, sec_last;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    dilithium_stream_framer #(.W(W), .MSG_MAX_BITS(MSG_MAX_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .sec_level  (sec_level),
        .msg_len    (msg_len),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sec_id     (sec_id),
        .sec_first  (sec_first),
        .sec_last   (sec_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic int num_sec(input logic [1:0] m);
        if (m == 2'b00) return 1;
        if (m == 2'b10) return 7;
        return 6;
    endfunction

    function automatic int pick(input int lv, input int a, input int b, input int c);
        return (lv == 0) ? a : (lv == 1) ? b : c;
    endfunction

    function automatic int ref_bits(input logic [1:0] m, input int lv, input int k, input int msg);
        if (m == 2'b10) begin
            if (k == 3) return pick(lv, 3072, 5120, 5376);
            if (k == 4) return pick(lv, 3072, 6144, 6144);
            if (k == 5) return pick(lv, 13312, 19968, 26624);
            if (k == 6) return msg;
        end else if (m == 2'b01) begin
            if (k == 1) return pick(lv, 10240, 15360, 20480);
            if (k == 3) return pick(lv, 18432, 25600, 35840);
            if (k == 4) return pick(lv, 672, 488, 664);
            if (k == 5) return msg;
        end
        return 256;
    endfunction

    function automatic int ref_sid(input logic [1:0] m, input int k);
        if (m == 2'b00) return 0;
        if (m == 2'b10) return (k < 6) ? k : 10;
        return (k == 0) ? 0 : k + 5;
    endfunction

    // cut_at >= 0 interrupts the run once that many words have been accepted.
    task automatic run_op(input logic [1:0] m, input int lv, input int msg, input bit bp,
                          input int cut_at, input bit cut_rst, output int got);
        int k = 0, j = 0, nw = 0, b, total_w = 0, cyc = 0;
        bit pend = 1'b0;
        logic [W-1:0] word, msk;
        exp_t e;
        for (int s = 0; s < num_sec(m); s++) total_w += (ref_bits(m, lv, s, msg) + W - 1) / W;
        got = 0;
        word = '0;
        sb.delete();
        @(negedge clk);
        mode = m; sec_level = 2'(lv); msg_len = ML'(msg); start = 1'b1;
        din_valid = 1'b0; dout_ready = 1'b0;
        while (got < total_w && cyc < CYC_LIMIT) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (!pend) begin
                b  = ref_bits(m, lv, k, msg);
                nw = (b + W - 1) / W;
                word = {$urandom, $urandom};
                msk = '1;
                if (j == nw - 1 && (b % W) != 0) msk = (W'(1) << (b % W)) - W'(1);
                e.data  = word & msk;
                e.sid   = 4'(ref_sid(m, k));
                e.first = (j == 0);
                e.last  = (j == nw - 1);
                sb.push_back(e);
                pend = 1'b1;
            end
            din        = word;
            din_valid  = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            dout_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (got == cut_at) begin
                din_valid = 1'b1; dout_ready = 1'b1;
                if (cut_rst) rst = 1'b1;
                else         abort = 1'b1;
            end
            #1;
            if (cyc == 1) begin
                chk("busy_on", busy, 1);
                chk("no_cfg_err", cfg_err, 0);
            end
            if (got == cut_at) begin
                if (cut_rst) begin
                    chk("rst_busy", busy, 0);
                    chk("rst_valid", dout_valid, 0);
                end else begin
                    chk("abort_done", done, 0);
                end
                @(negedge clk);
                rst = 1'b0; abort = 1'b0; din_valid = 1'b0;
                #1;
                chk("cut_busy", busy, 0);
                chk("cut_done", done, 0);
                chk("cut_ready", din_ready, 0);
                sb.delete();
                return;
            end
            chk("rdy_follow", din_ready, dout_ready);
            chk("vld_follow", dout_valid, din_valid);
            chk("no_early_done", done, 0);
            if (dout_valid && dout_ready) begin
                e = sb.pop_front();
                chk("data", dout, e.data);
                chk("sec_id", sec_id, e.sid);
                chk("first", sec_first, e.first);
                chk("last", sec_last, e.last);
                got++;
                pend = 1'b0;
                j++;
                if (j == nw) begin
                    j = 0;
                    k++;
                    while (k < num_sec(m) && ref_bits(m, lv, k, msg) == 0) k++;
                end
            end else if (dout_valid) begin
                e = sb[0];
                chk("stall_id", sec_id, e.sid);
                chk("stall_first", sec_first, e.first);
                chk("stall_last", sec_last, e.last);
            end
        end
        if (got < total_w) chk("timeout", got, total_w);
        @(negedge clk);
        din_valid = 1'b0; dout_ready = 1'b0;
        #1;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        @(negedge clk);
        #1;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic bad_start(input logic [1:0] m, input logic [1:0] lv, input int msg);
        @(negedge clk);
        mode = m; sec_level = lv; msg_len = ML'(msg); start = 1'b1;
        din_valid = 1'b1; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("cfg_err", cfg_err, 1);
        chk("bad_busy", busy, 0);
        chk("bad_ready", din_ready, 0);
        chk("bad_valid", dout_valid, 0);
        @(negedge clk);
        din_valid = 1'b0; dout_ready = 1'b0;
        #1;
        chk("cfg_err_drop", cfg_err, 0);
        chk("bad_idle", busy, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; sec_level = 2'd0;
        msg_len = '0; din = '1; din_valid = 1'b1; dout_ready = 1'b1;
        #12;
        chk("rst_dout", dout, 0);
        chk("rst_sec_id", sec_id, 0);
        chk("rst_first", sec_first, 0);
        chk("rst_last", sec_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 0, 0,   1'b0, -1, 1'b0, n); chk("kg_words", n, 4);
        run_op(2'b10, 0, 0,   1'b0, -1, 1'b0, n); chk("sign2_words", n, 316);
        run_op(2'b01, 1, 100, 1'b0, -1, 1'b0, n); chk("ver3_words", n, 658);
        run_op(2'b10, 2, 777, 1'b1, -1, 1'b0, n); chk("sign5_words", n, 621);

        bad_start(2'b00, 2'd3, 0);
        bad_start(2'b11, 2'd0, 0);
        bad_start(2'b10, 2'd1, MSG_MAX_BITS + 1);

        run_op(2'b10, 0, 64,  1'b0, 50,  1'b0, n);
        run_op(2'b00, 0, 0,   1'b0, -1,  1'b0, n); chk("kg_after_abort", n, 4);
        run_op(2'b01, 2, 300, 1'b1, 100, 1'b1, n);
        run_op(2'b00, 0, 0,   1'b1, -1,  1'b0, n); chk("kg_after_rst", n, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
